// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Copies a block of bytes from a source region to a destination region over
// the data memory's single port. It owns that port while busy: each byte takes
// one read cycle and then one write cycle. When the destination overlaps the
// tail of the source, the copy runs in descending address order so that no
// source byte is overwritten before it has been read.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset; aborts any transfer
//   start        request pulse, only looked at while idle
//   src_addr     first source address
//   dst_addr     first destination address
//   len          byte count 0..2^AW (larger values are clamped to 2^AW)
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle completion pulse
//   mem_addr     address to the data memory
//   mem_wr_en    write enable to the data memory
//   mem_dat_in   write data to the data memory
//   mem_dat_out  read data from the data memory (combinational from mem_addr)
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter int LW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_dat_in,
    input  logic [DW-1:0] mem_dat_out
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } state_t;

    localparam logic [LW-1:0] MAX_LEN = LW'(2 ** AW);

    state_t        state_reg;
    state_t        state_next;
    logic [AW-1:0] cur_src_reg;
    logic [AW-1:0] cur_dst_reg;
    logic [LW-1:0] remaining_reg;
    logic [DW-1:0] hold_reg;
    logic          backward_reg;

    // Request decode, only meaningful while idle.
    logic [LW-1:0] len_clamped;
    logic [AW-1:0] dst_offset;
    logic          start_backward;
    logic [AW-1:0] last_offset;
    logic [AW-1:0] addr_step;

    assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;

    // Distance from source to destination, modulo the memory size. If the
    // destination starts inside the source block, a forward copy would
    // clobber unread source bytes, so walk the block from its top end.
    assign dst_offset     = dst_addr - src_addr;
    assign start_backward = (dst_addr != src_addr) && (LW'(dst_offset) < len_clamped);

    // Offset of the last byte. For a full 2^AW transfer the low bits are zero
    // and the subtraction wraps to 2^AW-1, which is exactly what is wanted.
    assign last_offset = len_clamped[AW-1:0] - AW'(1);

    // +1 or -1 modulo 2^AW.
    assign addr_step = backward_reg ? {AW{1'b1}} : AW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_src_reg   <= '0;
            cur_dst_reg   <= '0;
            remaining_reg <= '0;
            hold_reg      <= '0;
            backward_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        backward_reg  <= start_backward;
                        remaining_reg <= len_clamped;
                        if (start_backward) begin
                            cur_src_reg <= src_addr + last_offset;
                            cur_dst_reg <= dst_addr + last_offset;
                        end else begin
                            cur_src_reg <= src_addr;
                            cur_dst_reg <= dst_addr;
                        end
                    end
                end
                RD: begin
                    hold_reg <= mem_dat_out;
                end
                WR: begin
                    remaining_reg <= remaining_reg - LW'(1);
                    cur_src_reg   <= cur_src_reg + addr_step;
                    cur_dst_reg   <= cur_dst_reg + addr_step;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and port outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        mem_addr   = '0;
        mem_wr_en  = 1'b0;
        mem_dat_in = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? FIN : RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                mem_addr   = cur_src_reg;
                state_next = WR;
            end
            WR: begin
                busy       = 1'b1;
                mem_addr   = cur_dst_reg;
                mem_wr_en  = 1'b1;
                mem_dat_in = hold_reg;
                // This write is the last one when a single byte remains.
                state_next = (remaining_reg == LW'(1)) ? FIN : RD;
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Directed bench for mem_copy_engine. Each scenario pushes the bus reads and
// writes it expects into queues; a monitor on the falling edge pops and
// compares every read and write cycle the engine presents. Timing, final
// memory contents and control outputs are checked by the stimulus process.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_dat_in;
    logic [DW-1:0] mem_dat_out;

    always #5 clk = ~clk;

    mem_copy_engine #(
        .AW(AW),
        .DW(DW),
        .LW(LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_wr_en  (mem_wr_en),
        .mem_dat_in (mem_dat_in),
        .mem_dat_out(mem_dat_out)
    );

    // Memory model: combinational read, write on the rising edge. The bench
    // preloads through a separate port only while the engine is idle.
    logic [7:0] tb_mem [0:255] = '{default: 8'h00};
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            tb_mem[mem_addr] <= mem_dat_in;
        end else if (pre_we) begin
            tb_mem[pre_addr] <= pre_data;
        end
    end

    assign mem_dat_out = tb_mem[mem_addr];

    // Scoreboard.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         done_count  = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: a write cycle is flagged by mem_wr_en, a read cycle by busy
    // without write or done.
    always @(negedge clk) begin
        wr_t e;
        if (done) done_count++;
        if (mem_wr_en) begin
            if (exp_wr.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_dat_in);
            end else begin
                e = exp_wr.pop_front();
                $display("write addr %02h data %02h", mem_addr, mem_dat_in);
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_dat_in), 32'(e.data));
            end
        end else if (busy && !done) begin
            if (exp_rd.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_read: addr %0h, expected no read", mem_addr);
            end else begin
                $display("read  addr %02h", mem_addr);
                check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue a request, then count cycles to done (done_lat = 0 on timeout).
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [LW-1:0] l,
                            output int done_lat, output int busy_cyc);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Inputs are free to change once accepted.
        src_addr = 8'h5A;
        dst_addr = 8'hA5;
        len      = 9'd3;
        done_lat = 0;
        busy_cyc = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                done_lat = c;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int lat;
    int bcyc;
    int snap;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_wr_en", 32'(mem_wr_en), 0);
        check("reset_addr", 32'(mem_addr), 0);
        check("reset_dat_in", 32'(mem_dat_in), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic forward copy.
        preload(8'h10, 8'hAA);
        preload(8'h11, 8'hBB);
        preload(8'h12, 8'hCC);
        preload(8'h13, 8'hDD);
        exp_rd.push_back(8'h10); exp_wr.push_back({8'h40, 8'hAA});
        exp_rd.push_back(8'h11); exp_wr.push_back({8'h41, 8'hBB});
        exp_rd.push_back(8'h12); exp_wr.push_back({8'h42, 8'hCC});
        exp_rd.push_back(8'h13); exp_wr.push_back({8'h43, 8'hDD});
        run_copy(8'h10, 8'h40, 9'd4, lat, bcyc);
        $display("basic copy: done latency %0d, busy cycles %0d", lat, bcyc);
        check("basic_done_lat", lat, 9);
        check("basic_busy_cyc", bcyc, 9);
        check("basic_dst3", 32'(tb_mem[8'h43]), 32'h DD);
        check("basic_src0", 32'(tb_mem[8'h10]), 32'h AA);

        // Overlap, destination above source: descending order.
        preload(8'h10, 8'h01);
        preload(8'h11, 8'h02);
        preload(8'h12, 8'h03);
        preload(8'h13, 8'h04);
        exp_rd.push_back(8'h13); exp_wr.push_back({8'h15, 8'h04});
        exp_rd.push_back(8'h12); exp_wr.push_back({8'h14, 8'h03});
        exp_rd.push_back(8'h11); exp_wr.push_back({8'h13, 8'h02});
        exp_rd.push_back(8'h10); exp_wr.push_back({8'h12, 8'h01});
        run_copy(8'h10, 8'h12, 9'd4, lat, bcyc);
        $display("overlap backward: done latency %0d", lat);
        check("bwd_done_lat", lat, 9);
        check("bwd_mem12", 32'(tb_mem[8'h12]), 32'h01);
        check("bwd_mem15", 32'(tb_mem[8'h15]), 32'h04);

        // Overlap, destination below source: ascending order.
        preload(8'h10, 8'h01);
        preload(8'h11, 8'h02);
        preload(8'h12, 8'h03);
        preload(8'h13, 8'h04);
        exp_rd.push_back(8'h12); exp_wr.push_back({8'h10, 8'h03});
        exp_rd.push_back(8'h13); exp_wr.push_back({8'h11, 8'h04});
        run_copy(8'h12, 8'h10, 9'd2, lat, bcyc);
        $display("overlap forward: done latency %0d", lat);
        check("fwd_done_lat", lat, 5);
        check("fwd_mem11", 32'(tb_mem[8'h11]), 32'h04);

        // Source wraps past the top of memory.
        preload(8'hFE, 8'h11);
        preload(8'hFF, 8'h22);
        preload(8'h00, 8'h33);
        preload(8'h01, 8'h44);
        exp_rd.push_back(8'hFE); exp_wr.push_back({8'h80, 8'h11});
        exp_rd.push_back(8'hFF); exp_wr.push_back({8'h81, 8'h22});
        exp_rd.push_back(8'h00); exp_wr.push_back({8'h82, 8'h33});
        exp_rd.push_back(8'h01); exp_wr.push_back({8'h83, 8'h44});
        run_copy(8'hFE, 8'h80, 9'd4, lat, bcyc);
        $display("wrap copy: done latency %0d", lat);
        check("wrap_done_lat", lat, 9);

        // Zero length: no bus activity, done in the next cycle.
        run_copy(8'h30, 8'h31, 9'd0, lat, bcyc);
        $display("len 0: done latency %0d, busy cycles %0d", lat, bcyc);
        check("len0_done_lat", lat, 1);
        check("len0_busy_cyc", bcyc, 1);

        // Start while busy is ignored.
        for (int i = 0; i < 8; i++) begin
            preload(8'(8'h20 + i), 8'(8'h50 + i));
        end
        for (int i = 0; i < 8; i++) begin
            exp_rd.push_back(8'(8'h20 + i));
            exp_wr.push_back({8'(8'h60 + i), 8'(8'h50 + i)});
        end
        snap     = done_count;
        src_addr = 8'h20;
        dst_addr = 8'h60;
        len      = 9'd8;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dst_addr = 8'hA0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        $display("start while busy: %0d done pulses", done_count - snap);
        check("busy_start_dones", done_count - snap, 1);
        check("busy_start_mem67", 32'(tb_mem[8'h67]), 32'h57);
        check("busy_start_memA0", 32'(tb_mem[8'hA0]), 32'h00);

        // Reset during the third read, so the third write never happens.
        exp_rd.push_back(8'h20); exp_wr.push_back({8'hC0, 8'h50});
        exp_rd.push_back(8'h21); exp_wr.push_back({8'hC1, 8'h51});
        exp_rd.push_back(8'h22);
        snap     = done_count;
        src_addr = 8'h20;
        dst_addr = 8'hC0;
        len      = 9'd8;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_wr_en", 32'(mem_wr_en), 0);
        check("abort_addr", 32'(mem_addr), 0);
        repeat (30) @(posedge clk);
        #1;
        $display("reset abort: %0d done pulses", done_count - snap);
        check("abort_dones", done_count - snap, 0);
        check("abort_memC1", 32'(tb_mem[8'hC1]), 32'h51);
        check("abort_memC2", 32'(tb_mem[8'hC2]), 32'h00);

        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_reads", exp_rd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
